urish_silife_max: RTL and testbench



---
 rtl/urish_silife_max.sv | 82 ++++++++
 tb/tb_urish_silife_max.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urish_silife_max.sv
// Game of Life engine: 32x8 cell grid, parallel generation update,
// host row writes via uio_in and combinational row readback on uo_out.
module urish_silife_max (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       wr_en;
    logic       en;
    logic [4:0] row_sel;
    logic       unused_in;

    logic [7:0] grid_q   [32];
    logic [7:0] grid_d   [32];
    logic [7:0] next_gen [32];
    logic [9:0] pad      [34];

    assign wr_en     = ui_in[7];
    assign en        = ui_in[6];
    assign row_sel   = ui_in[4:0];
    assign unused_in = &{1'b0, ena, ui_in[5]};

    assign uo_out  = grid_q[row_sel];
    assign uio_out = '0;
    assign uio_oe  = '0;

    // Grid framed by a ring of permanently dead cells, so every cell sees
    // the same 3x3 window and edges need no special casing.
    always_comb begin
        pad[0]  = '0;
        pad[33] = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            pad[r+1] = {1'b0, grid_q[r], 1'b0};
        end
    end

    always_comb begin
        logic [3:0] n;
        n = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            next_gen[r] = '0;
            for (int unsigned c = 0; c < 8; c++) begin
                n = 4'(pad[r][c])   + 4'(pad[r][c+1])   + 4'(pad[r][c+2])
                  + 4'(pad[r+1][c])                     + 4'(pad[r+1][c+2])
                  + 4'(pad[r+2][c]) + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
                next_gen[r][c] = (n == 4'd3) | (grid_q[r][c] & (n == 4'd2));
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < 32; r++) begin
            grid_d[r] = grid_q[r];
        end
        if (wr_en) begin
            grid_d[row_sel] = uio_in;
        end else if (en) begin
            for (int unsigned r = 0; r < 32; r++) begin
                grid_d[r] = next_gen[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 32; r++) begin
                grid_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < 32; r++) begin
                grid_q[r] <= grid_d[r];
            end
        end
    end

endmodule

// File: tb/tb_urish_silife_max.sv
// Self-checking bench for urish_silife_max: directed Life patterns plus
// randomized write/step/hold traffic against a cell-by-cell reference model.
`timescale 1ns/1ps
module tb_urish_silife_max;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [7:0] mrow [32];

    urish_silife_max dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count live neighbours directly, treating off-grid as dead.
    function automatic void model_step();
        logic [7:0] nxt [32];
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 32 &&
                            (c + dc) >= 0 && (c + dc) < 8) begin
                            n = n + int'(mrow[r+dr][c+dc]);
                        end
                    end
                end
                nxt[r][c] = (n == 3) || (mrow[r][c] && n == 2);
            end
        end
        for (int r = 0; r < 32; r++) mrow[r] = nxt[r];
    endfunction

    task automatic cycle(input logic wr, input logic st, input logic [4:0] sel,
                         input logic [7:0] data);
        ui_in  = {wr, st, 1'($urandom), sel};
        uio_in = data;
        ena    = 1'($urandom);
        @(posedge clk);
        if (wr) mrow[sel] = data;
        else if (st) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) mrow[r] = '0;
    endtask

    task automatic test_reset();
        ui_in  = '0;
        uio_in = '0;
        ena    = 1'b0;
        rst_n  = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) mrow[r] = '0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) begin
            ui_in = {3'b000, 5'(r)};
            #1;
            n_cmp++;
            if (uo_out !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_row%0d got=%h exp=00", r, uo_out);
            end
        end
        n_cmp++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            n_bad++;
            $display("FAIL uio_tie got=%h/%h exp=00/00", uio_out, uio_oe);
        end
    endtask

    task automatic test_write_readback();
        logic [7:0] v;
        do_reset();
        for (int r = 0; r < 32; r++) begin
            v = 8'(r * 7 + 1);
            cycle(1'b1, 1'b1, 5'(r), v);
            n_cmp++;
            if (uo_out !== v) begin
                n_bad++;
                $display("FAIL wr_latency_row%0d got=%h exp=%h", r, uo_out, v);
            end
        end
        for (int r = 0; r < 32; r++) begin
            v = 8'(r * 7 + 1);
            ui_in = {3'b000, 5'(r)};
            #1;
            n_cmp++;
            if (uo_out !== v) begin
                n_bad++;
                $display("FAIL readback_row%0d got=%h exp=%h", r, uo_out, v);
            end
        end
    endtask

    task automatic test_blinker();
        logic [7:0] exp [32];
        do_reset();
        cycle(1'b1, 1'b0, 5'd4, 8'h00);
        cycle(1'b1, 1'b0, 5'd5, 8'h1C);
        cycle(1'b1, 1'b0, 5'd6, 8'h00);
        for (int ph = 0; ph < 2; ph++) begin
            cycle(1'b0, 1'b1, 5'd0, 8'h00);
            for (int r = 0; r < 32; r++) exp[r] = 8'h00;
            if (ph == 0) begin
                exp[4] = 8'h08; exp[5] = 8'h08; exp[6] = 8'h08;
            end else begin
                exp[5] = 8'h1C;
            end
            for (int r = 0; r < 32; r++) begin
                ui_in = {3'b000, 5'(r)};
                #1;
                n_cmp++;
                if (uo_out !== exp[r]) begin
                    n_bad++;
                    $display("FAIL blinker_ph%0d_row%0d got=%h exp=%h", ph, r, uo_out, exp[r]);
                end
            end
        end
    endtask

    task automatic test_still_life();
        do_reset();
        cycle(1'b1, 1'b0, 5'd10, 8'h06);
        cycle(1'b1, 1'b0, 5'd11, 8'h06);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 5'd10, 8'h00);
        for (int r = 9; r <= 12; r++) begin
            ui_in = {3'b000, 5'(r)};
            #1;
            n_cmp++;
            if (uo_out !== ((r == 10 || r == 11) ? 8'h06 : 8'h00)) begin
                n_bad++;
                $display("FAIL block_row%0d got=%h", r, uo_out);
            end
        end
    endtask

    task automatic test_edges();
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e31;
        do_reset();
        cycle(1'b1, 1'b0, 5'd0, 8'h07);
        for (int ph = 0; ph < 2; ph++) begin
            cycle(1'b0, 1'b1, 5'd0, 8'h00);
            e0  = (ph == 0) ? 8'h02 : 8'h00;
            e1  = e0;
            e31 = 8'h00;
            ui_in = 8'd0;  #1; n_cmp++;
            if (uo_out !== e0)  begin n_bad++; $display("FAIL top_ph%0d_row0 got=%h exp=%h", ph, uo_out, e0); end
            ui_in = 8'd1;  #1; n_cmp++;
            if (uo_out !== e1)  begin n_bad++; $display("FAIL top_ph%0d_row1 got=%h exp=%h", ph, uo_out, e1); end
            ui_in = 8'd31; #1; n_cmp++;
            if (uo_out !== e31) begin n_bad++; $display("FAIL top_ph%0d_row31 got=%h exp=%h", ph, uo_out, e31); end
        end
        do_reset();
        cycle(1'b1, 1'b0, 5'd19, 8'h80);
        cycle(1'b1, 1'b0, 5'd20, 8'h80);
        cycle(1'b1, 1'b0, 5'd21, 8'h80);
        cycle(1'b0, 1'b1, 5'd0, 8'h00);
        for (int r = 18; r <= 22; r++) begin
            ui_in = {3'b000, 5'(r)};
            #1;
            n_cmp++;
            if (uo_out !== ((r == 20) ? 8'hC0 : 8'h00)) begin
                n_bad++;
                $display("FAIL left_edge_row%0d got=%h", r, uo_out);
            end
        end
        // Bottom/right corner: 3 cells around (31,0) give a birth there only.
        do_reset();
        cycle(1'b1, 1'b0, 5'd30, 8'h03);
        cycle(1'b1, 1'b0, 5'd31, 8'h02);
        cycle(1'b0, 1'b1, 5'd0, 8'h00);
        ui_in = 8'd31; #1; n_cmp++;
        if (uo_out !== 8'h03) begin n_bad++; $display("FAIL corner_row31 got=%h exp=03", uo_out); end
        ui_in = 8'd30; #1; n_cmp++;
        if (uo_out !== 8'h03) begin n_bad++; $display("FAIL corner_row30 got=%h exp=03", uo_out); end
    endtask

    task automatic test_random();
        logic       wr;
        logic       st;
        logic [4:0] sel;
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int r = 0; r < 32; r++) begin
                cycle(1'b1, 1'($urandom), 5'(r), 8'($urandom) & 8'($urandom | (round << 6)));
            end
            for (int i = 0; i < 60; i++) begin
                wr  = ($urandom_range(0, 9) == 0);
                st  = ($urandom_range(0, 3) != 0);
                sel = 5'($urandom);
                cycle(wr, st, sel, 8'($urandom));
                n_cmp++;
                if (uo_out !== mrow[sel]) begin
                    n_bad++;
                    $display("FAIL rand_r%0d_c%0d row%0d got=%h exp=%h", round, i, sel, uo_out, mrow[sel]);
                end
            end
            for (int r = 0; r < 32; r++) begin
                ui_in = {3'b000, 5'(r)};
                #1;
                n_cmp++;
                if (uo_out !== mrow[r]) begin
                    n_bad++;
                    $display("FAIL rand_sweep_r%0d_row%0d got=%h exp=%h", round, r, uo_out, mrow[r]);
                end
            end
        end
    endtask

    task automatic test_reset_during_step();
        do_reset();
        for (int r = 0; r < 32; r++) cycle(1'b1, 1'b0, 5'(r), 8'($urandom) | 8'h01);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'd0, 8'h00);
        ui_in = {3'b010, 5'd7};
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_bad++;
            $display("FAIL async_clear got=%h exp=00", uo_out);
        end
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) mrow[r] = '0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'(i), 8'h00);
        for (int r = 0; r < 32; r++) begin
            ui_in = {3'b000, 5'(r)};
            #1;
            n_cmp++;
            if (uo_out !== 8'h00) begin
                n_bad++;
                $display("FAIL post_reset_dead_row%0d got=%h exp=00", r, uo_out);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_write_readback();
        test_blinker();
        test_still_life();
        test_edges();
        test_random();
        test_reset_during_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
